alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle shift-add multiply sequencer that implements LEGv8 MUL (low WIDTH bits of the product) on the existing shared ALU instead of a dedicated multiplier.
- Sits beside the EX stage. While BUSY is high it owns the ALU operand and control inputs; the EX operand mux selects this block's ALU_A/ALU_B/ALU_CTRL on BUSY.
- Low-half product is identical for signed and unsigned operands, so no sign handling is needed.

Parameters:
- WIDTH, 64, operand/result width; must match the ALU width.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  one-cycle request; sampled only in IDLE.
- ABORT  input  1  synchronous cancel (pipeline flush).
- MCAND  input  WIDTH  multiplicand, latched on accepted START.
- MPLIER  input  WIDTH  multiplier, latched on accepted START.
- BUSY  output  1  high in RUN; ALU is owned by this block.
- DONE  output  1  one-cycle pulse, RESULT valid.
- RESULT  output  WIDTH  product low half, held until next accepted START.
- ITER  output  CNT_W  ALU add-cycles used by the last/current operation.
- ALU_A  output  WIDTH  to ALU A.
- ALU_B  output  WIDTH  to ALU B.
- ALU_CTRL  output  4  to ALU control.
- ALU_RESULT  input  WIDTH  from ALU output (combinational, same cycle).

Behaviour:
- State machine is IDLE, RUN, DONE.
- Registers: P (partial product), M (shifted multiplicand), Q (shifted multiplier), ITER.
- Reset: state=IDLE, P=M=Q=0, ITER=0, BUSY=0, DONE=0, RESULT=0.
- IDLE:
  - START && !ABORT: latch M=MCAND, Q=MPLIER, P=0, ITER=0.
  - If MPLIER==0, go directly to DONE (RESULT=0). Otherwise go to RUN.
- RUN, each cycle:
  - Drive ALU_A=P, ALU_CTRL=4'd2 (ADD), ALU_B = Q[0] ? M : 0.
  - Register P<=ALU_RESULT, M<=M<<1 (shifted-out bits discarded), Q<=Q>>1, ITER<=ITER+1.
  - If (Q>>1)==0, go to DONE; otherwise stay in RUN.
- DONE: DONE=1 for exactly one cycle; RESULT=P; return to IDLE. RESULT holds until the next accepted START.
- Latency: START at cycle t with highest set multiplier bit k gives RUN at t+1..t+k+1 and DONE at t+k+2.
  - MPLIER=0: DONE at t+1.
  - MPLIER=1: DONE at t+2.
  - All-ones multiplier: DONE at t+65 for WIDTH=64.
  - ITER=k+1 at DONE.
- Outputs outside RUN: ALU_A=0, ALU_B=0, ALU_CTRL=4'd2; BUSY=0.
- BUSY and ALU_* outputs decode from the state register only, with no combinational path from START.
- Overflow: the product wraps modulo 2^WIDTH; no flag.
- START while in RUN or DONE is ignored, with no queueing.
- ABORT:
  - In RUN: return to IDLE next cycle, no DONE pulse, RESULT unchanged.
  - In IDLE: ABORT has priority over START in the same cycle.
  - In DONE: ignored; the DONE pulse still occurs.
- RST_N deasserted mid-RUN: immediate return to reset values with no DONE pulse.

Decomposition:
- Shared package alu_pkg:
  - ALU control code constants: AND=0, ORR=1, ADD=2, SUB=6, PASSB=7, NOR=12. The ALU and this block both import these.
  - Enum mul_state_t {IDLE, RUN, DONE}.
- No sub-module inside this block.
- The bench instantiates the existing ALU and connects it to ALU_A/ALU_B/ALU_CTRL/ALU_RESULT.

Test Plan:
- Reset mid-RUN: RST_N low during RUN -> all outputs at reset values, no DONE pulse, then accept a new START normally.
- Basic multiply: MCAND=7, MPLIER=6 (k=2) -> BUSY high cycles t+1..t+3, DONE at t+4, RESULT=42, ITER=3.
- Zero multiplier: MPLIER=0, MCAND=0xDEAD -> DONE at t+1, RESULT=0, BUSY never high.
- Wrap and signed behaviour, two cases:
  - MCAND=0xFFFF_FFFF_FFFF_FFFF, MPLIER=2 -> RESULT=0xFFFF_FFFF_FFFF_FFFE.
  - MCAND=-3, MPLIER=5 -> RESULT=0xFFFF_FFFF_FFFF_FFF1.
- Max latency: MPLIER=0x8000_0000_0000_0000, MCAND=1 -> DONE at t+65, RESULT=0x8000_0000_0000_0000, ITER=64; ALU_CTRL=2 throughout RUN.
- ABORT and START interactions:
  - ABORT on the third RUN cycle -> IDLE next cycle, no DONE, RESULT keeps its prior value.
  - START pulsed during RUN -> ignored.
  - START with ABORT in IDLE -> not accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Holds the 4-bit ALU control codes used by the ALU and by every block that
// borrows it, plus the state encoding of the shift-add multiply sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_ORR   = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_PASSB = 4'd7;
    localparam logic [3:0] ALU_NOR   = 4'd12;

    // Multiply sequencer states: idle, add/shift loop, one-cycle result pulse.
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU of the EX stage.
// Ports:
//   a_i, b_i   operands
//   ctrl_i     operation select (alu_pkg ALU_* codes)
//   result_o   operation result, same cycle
//   zero_o     high when result_o is zero
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       ctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    always_comb begin
        result_o = '0;
        case (ctrl_i)
            ALU_AND:   result_o = a_i & b_i;
            ALU_ORR:   result_o = a_i | b_i;
            ALU_ADD:   result_o = a_i + b_i;
            ALU_SUB:   result_o = a_i - b_i;
            ALU_PASSB: result_o = b_i;
            ALU_NOR:   result_o = ~(a_i | b_i);
            default:   result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add multiply sequencer producing the low WIDTH bits of MCAND*MPLIER
// by borrowing the shared ALU adder, one add per multiplier bit up to the
// highest set bit. The low half is sign-agnostic, so no sign handling exists.
// Ports:
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   START, ABORT      request (sampled in IDLE only), synchronous cancel
//   MCAND, MPLIER     operands, latched on an accepted START
//   BUSY              high while the ALU is owned (RUN)
//   DONE, RESULT      one-cycle completion pulse, product held until next START
//   ITER              ALU add cycles used by the last/current operation
//   ALU_A/B/CTRL      drive the shared ALU; ALU_RESULT is its combinational output
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] MCAND,
    input  logic [WIDTH-1:0] MPLIER,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [CNT_W-1:0] ITER,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [3:0]       ALU_CTRL,
    input  logic [WIDTH-1:0] ALU_RESULT
);

    mul_state_t       state_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] q_q;
    logic [CNT_W-1:0] iter_q;
    logic [WIDTH-1:0] result_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= MS_IDLE;
            p_q      <= '0;
            m_q      <= '0;
            q_q      <= '0;
            iter_q   <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                MS_IDLE: begin
                    if (START && !ABORT) begin
                        m_q    <= MCAND;
                        q_q    <= MPLIER;
                        p_q    <= '0;
                        iter_q <= '0;
                        if (MPLIER == '0) begin
                            result_q <= '0;
                            state_q  <= MS_DONE;
                        end else begin
                            state_q  <= MS_RUN;
                        end
                    end
                end
                MS_RUN: begin
                    if (ABORT) begin
                        state_q <= MS_IDLE;
                    end else begin
                        p_q    <= ALU_RESULT;
                        m_q    <= m_q << 1;
                        q_q    <= q_q >> 1;
                        iter_q <= iter_q + CNT_W'(1);
                        // RESULT is captured straight from the adder on the final
                        // add so it is already valid during the DONE pulse.
                        if ((q_q >> 1) == '0) begin
                            result_q <= ALU_RESULT;
                            state_q  <= MS_DONE;
                        end
                    end
                end
                MS_DONE: state_q <= MS_IDLE;
                default: state_q <= MS_IDLE;
            endcase
        end
    end

    // ALU drive depends only on registered state, never on START.
    assign BUSY     = (state_q == MS_RUN);
    assign DONE     = (state_q == MS_DONE);
    assign RESULT   = result_q;
    assign ITER     = iter_q;
    assign ALU_CTRL = ALU_ADD;
    assign ALU_A    = BUSY ? p_q : '0;
    assign ALU_B    = (BUSY && q_q[0]) ? m_q : '0;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic             CLK;
    logic             RST_N;
    logic             START;
    logic             ABORT;
    logic [WIDTH-1:0] MCAND;
    logic [WIDTH-1:0] MPLIER;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] RESULT;
    logic [CNT_W-1:0] ITER;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .ABORT      (ABORT),
        .MCAND      (MCAND),
        .MPLIER     (MPLIER),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .RESULT     (RESULT),
        .ITER       (ITER),
        .ALU_A      (alu_a),
        .ALU_B      (alu_b),
        .ALU_CTRL   (alu_ctrl),
        .ALU_RESULT (alu_result)
    );

    alu #(.WIDTH(WIDTH)) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .ctrl_i   (alu_ctrl),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] res;
        int               iter;
        int               busy;
        int               done_cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
        end
    endtask

    // Monitor: pops an expectation on every DONE pulse.
    int busy_cnt  = 0;
    bit prev_busy = 0;
    bit alu_bad   = 0;
    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            busy_cnt  = 0;
            prev_busy = 0;
        end else begin
            if (alu_ctrl != 4'd2) alu_bad = 1;
            if (!BUSY && (alu_a != '0 || alu_b != '0)) alu_bad = 1;
            if (BUSY) busy_cnt++;
            if (DONE) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, RESULT, e.res);
                    chk({e.name, "_iter"}, 64'(ITER), 64'(e.iter));
                    chk({e.name, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
                    chk({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.busy));
                    chk({e.name, "_alu_idle_ctrl"}, 64'(alu_bad), 64'd0);
                end
                busy_cnt = 0;
                alu_bad  = 0;
            end else if (prev_busy && !BUSY) begin
                busy_cnt = 0;
            end
            prev_busy = BUSY;
        end
    end

    task automatic push_exp(input string name, input logic [WIDTH-1:0] res,
                            input int iter, input int lat, input int c);
        exp_t e;
        e.name     = name;
        e.res      = res;
        e.iter     = iter;
        e.busy     = iter;
        e.done_cyc = c + lat;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            chk({name, "_timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    // Pulse START for one cycle and record the hand-computed expectation.
    task automatic issue(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] res, input int iter, input int lat);
        @(posedge CLK); #1;
        MCAND  = a;
        MPLIER = b;
        START  = 1'b1;
        push_exp(name, res, iter, lat, cyc);
        @(posedge CLK); #1;
        START  = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N  = 1'b0;
        START  = 1'b0;
        ABORT  = 1'b0;
        MCAND  = '0;
        MPLIER = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_busy", 64'(BUSY), 64'd0);
        chk("reset_done", 64'(DONE), 64'd0);
        chk("reset_result", RESULT, 64'd0);
        chk("reset_iter", 64'(ITER), 64'd0);
        chk("reset_alu_a", alu_a, 64'd0);
        chk("reset_alu_b", alu_b, 64'd0);
        chk("reset_alu_ctrl", 64'(alu_ctrl), 64'd2);
        RST_N = 1'b1;

        issue("basic", 64'd7, 64'd6, 64'd42, 3, 4);

        // Reset while running: 5 * 0xF0 would take 8 add cycles.
        @(posedge CLK); #1;
        MCAND = 64'd5; MPLIER = 64'hF0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("midrun_busy_before_reset", 64'(BUSY), 64'd1);
        RST_N = 1'b0;
        #1;
        chk("midrun_rst_busy", 64'(BUSY), 64'd0);
        chk("midrun_rst_done", 64'(DONE), 64'd0);
        chk("midrun_rst_result", RESULT, 64'd0);
        chk("midrun_rst_iter", 64'(ITER), 64'd0);
        chk("midrun_rst_alu_a", alu_a, 64'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        issue("zero_mplier", 64'hDEAD, 64'd0, 64'd0, 0, 1);
        issue("wrap_ones_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2, 3);
        issue("neg3_x5", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 3, 4);
        issue("max_latency", 64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64, 65);
        issue("mplier_one", 64'h1234, 64'd1, 64'h1234, 1, 2);
        issue("ones_mplier", 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 64, 65);
        issue("wide_x16", 64'h1_0000_0001, 64'h10, 64'h10_0000_0010, 5, 6);

        // ABORT on the third RUN cycle of 5 * 0xFF.
        @(posedge CLK); #1;
        MCAND = 64'd5; MPLIER = 64'hFF; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("abort_busy_third_run", 64'(BUSY), 64'd1);
        ABORT = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        chk("abort_busy_after", 64'(BUSY), 64'd0);
        chk("abort_done_after", 64'(DONE), 64'd0);
        repeat (5) @(posedge CLK);
        #1;
        chk("abort_result_kept", RESULT, 64'h10_0000_0010);

        // START pulsed during RUN must be ignored.
        @(posedge CLK); #1;
        MCAND = 64'd3; MPLIER = 64'h10; START = 1'b1;
        push_exp("start_in_run", 64'h30, 5, 6, cyc);
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        MCAND = 64'd99; MPLIER = 64'd1; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_idle("start_in_run");
        repeat (5) @(posedge CLK);
        #1;
        chk("start_in_run_result_final", RESULT, 64'h30);

        // START together with ABORT in IDLE is not accepted.
        @(posedge CLK); #1;
        MCAND = 64'd9; MPLIER = 64'd0; START = 1'b1; ABORT = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; ABORT = 1'b0;
        chk("start_abort_done", 64'(DONE), 64'd0);
        repeat (4) @(posedge CLK);
        #1;
        chk("start_abort_busy", 64'(BUSY), 64'd0);
        chk("start_abort_result", RESULT, 64'h30);
        chk("start_abort_iter", 64'(ITER), 64'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
